// File: rtl/fetch_dispatch_queue_if.sv
// Decoder-to-rename bundle for the fetch/dispatch queue: push lanes and acceptance
// on one side, head window, pop count and status on the other.
interface fetch_dispatch_queue_if #(
  parameter int N_WAY = 3,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  localparam int NW = $clog2(N_WAY) + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                            flush;
  logic [N_WAY-1:0]                in_valid;
  logic [N_WAY-1:0][XLEN-1:0]      in_PC;
  logic [N_WAY-1:0][XLEN-1:0]      in_inst;
  logic [NW-1:0]                   in_accept_num;
  logic [N_WAY-1:0]                out_valid;
  logic [N_WAY-1:0][XLEN-1:0]      out_PC;
  logic [N_WAY-1:0][XLEN-1:0]      out_inst;
  logic [NW-1:0]                   dispatched_num;
  logic [CW-1:0]                   count;
  logic [CW-1:0]                   free_slots;
  logic                            underflow_err;

  modport master (
    output flush, in_valid, in_PC, in_inst, dispatched_num,
    input  in_accept_num, out_valid, out_PC, out_inst, count, free_slots, underflow_err
  );

  modport slave (
    input  flush, in_valid, in_PC, in_inst, dispatched_num,
    output in_accept_num, out_valid, out_PC, out_inst, count, free_slots, underflow_err
  );
endinterface

// File: rtl/fetch_dispatch_queue.sv
// N_WAY-wide circular instruction queue between decode and rename; pushes a valid
// prefix of lanes at the tail and exposes an N_WAY head window with zero bypass.
module fetch_dispatch_queue #(
  parameter int N_WAY = 3,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input logic                   clock,
  input logic                   reset,
  fetch_dispatch_queue_if.slave q
);
  localparam int NW = $clog2(N_WAY) + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 1;

  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            err;
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_inst [DEPTH];

  logic [CW-1:0]   prefix, free, accept, avail, pop;
  logic            hole, underflow;

  // Offsets never exceed DEPTH, so one conditional subtract wraps any pointer sum.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [CW-1:0] off);
    logic [SW-1:0] sum;
    sum = SW'(ptr) + SW'(off);
    if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
    return PW'(sum);
  endfunction

  // NOTE: every always_comb output gets a default before the loop, otherwise a
  // path that skips the assignment infers a latch; blocking '=' is correct here.
  always_comb begin
    prefix = '0;
    hole   = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!q.in_valid[i]) hole = 1'b1;
      else if (!hole)     prefix = prefix + CW'(1);
    end
  end

  // Push room comes only from registered occupancy; same-cycle pops never help.
  assign free      = CW'(DEPTH) - count;
  assign accept    = q.flush ? '0 : ((prefix < free) ? prefix : free);
  assign avail     = (count > CW'(N_WAY)) ? CW'(N_WAY) : count;
  assign underflow = !q.flush && (CW'(q.dispatched_num) > avail);
  assign pop       = q.flush ? '0 : (underflow ? avail : CW'(q.dispatched_num));

  assign q.in_accept_num = NW'(accept);
  assign q.count         = count;
  assign q.free_slots    = free;
  assign q.underflow_err = err;

  always_comb begin
    q.out_valid = '0;
    q.out_PC    = '0;
    q.out_inst  = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (CW'(i) < count) begin
        q.out_valid[i] = 1'b1;
        q.out_PC[i]    = mem_pc[wrap_add(head, CW'(i))];
        q.out_inst[i]  = mem_inst[wrap_add(head, CW'(i))];
      end
    end
  end

  // NOTE: payload storage has no reset; count and the pointers alone decide which
  // entries are live, so stale data is never observable.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (CW'(i) < accept) begin
        mem_pc[wrap_add(tail, CW'(i))]   <= q.in_PC[i];
        mem_inst[wrap_add(tail, CW'(i))] <= q.in_inst[i];
      end
    end
  end

  // NOTE: state registers use non-blocking '<=' so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= wrap_add(head, pop);
      tail  <= wrap_add(tail, accept);
      count <= count + accept - pop;
      if (underflow) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_dispatch_queue.sv
// Self-checking bench: a queue-based reference model is compared against the DUT
// every negative edge, plus directed scenarios with hand-computed expectations.
module tb_fetch_dispatch_queue;
  localparam int N_WAY = 3;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int NW    = $clog2(N_WAY) + 1;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_dispatch_queue_if #(.N_WAY(N_WAY), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  fetch_dispatch_queue #(.N_WAY(N_WAY), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .q     (bus)
  );

  entry_t model_q[$];
  bit     model_err;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int prefix_len();
    int p = 0;
    while (p < N_WAY && bus.in_valid[p] === 1'b1) p++;
    return p;
  endfunction

  function automatic int exp_accept();
    int room = DEPTH - model_q.size();
    int p    = prefix_len();
    if (bus.flush) return 0;
    return (p < room) ? p : room;
  endfunction

  function automatic int exp_avail();
    return (model_q.size() < N_WAY) ? model_q.size() : N_WAY;
  endfunction

  task automatic model_step();
    int acc, d, e;
    if (reset) begin
      model_q.delete();
      model_err = 1'b0;
    end else if (bus.flush) begin
      model_q.delete();
    end else begin
      acc = exp_accept();
      d   = int'(bus.dispatched_num);
      if (d > exp_avail()) model_err = 1'b1;
      e = (d < exp_avail()) ? d : exp_avail();
      for (int k = 0; k < e; k++) void'(model_q.pop_front());
      for (int k = 0; k < acc; k++) model_q.push_back('{pc: bus.in_PC[k], inst: bus.in_inst[k]});
    end
  endtask

  task automatic compare_all();
    logic [XLEN-1:0] epc, einst;
    check("in_accept_num", 64'(bus.in_accept_num), 64'(exp_accept()));
    check("count", 64'(bus.count), 64'(model_q.size()));
    check("free_slots", 64'(bus.free_slots), 64'(DEPTH - model_q.size()));
    check("underflow_err", 64'(bus.underflow_err), 64'(model_err));
    for (int i = 0; i < N_WAY; i++) begin
      epc   = (i < model_q.size()) ? model_q[i].pc   : '0;
      einst = (i < model_q.size()) ? model_q[i].inst : '0;
      check($sformatf("out_valid[%0d]", i), 64'(bus.out_valid[i]), 64'(i < model_q.size()));
      check($sformatf("out_PC[%0d]", i), 64'(bus.out_PC[i]), 64'(epc));
      check($sformatf("out_inst[%0d]", i), 64'(bus.out_inst[i]), 64'(einst));
    end
  endtask

  always @(posedge clock or posedge reset) model_step();
  always @(negedge clock) compare_all();

  task automatic drive(input logic f, input logic [N_WAY-1:0] v, input logic [XLEN-1:0] base, input int disp);
    bus.flush          = f;
    bus.in_valid       = v;
    bus.dispatched_num = NW'(disp);
    for (int i = 0; i < N_WAY; i++) begin
      bus.in_PC[i]   = base + XLEN'(4 * i);
      bus.in_inst[i] = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 0);
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    #1;
    check({tag, " count"}, 64'(bus.count), 64'd0);
    check({tag, " free_slots"}, 64'(bus.free_slots), 64'(DEPTH));
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " underflow_err"}, 64'(bus.underflow_err), 64'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, '0, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("reset count", 64'(bus.count), 64'd0);
    check("reset free_slots", 64'(bus.free_slots), 64'(DEPTH));
    check("reset out_valid", 64'(bus.out_valid), 64'd0);

    // Three-lane push, visible only after the edge.
    drive(1'b0, 3'b111, 32'h0, 0);
    #1 check("push3 accept", 64'(bus.in_accept_num), 64'd3);
    check("push3 no bypass", 64'(bus.out_valid), 64'd0);
    tick(); idle();
    check("push3 count", 64'(bus.count), 64'd3);
    check("push3 out_valid", 64'(bus.out_valid), 64'h7);
    check("push3 pc0", 64'(bus.out_PC[0]), 64'h0);
    check("push3 pc1", 64'(bus.out_PC[1]), 64'h4);
    check("push3 pc2", 64'(bus.out_PC[2]), 64'h8);
    check("push3 free_slots", 64'(bus.free_slots), 64'd5);
    drive(1'b0, '0, '0, 3); tick();

    // A hole in the valid mask ends the accepted prefix.
    drive(1'b0, 3'b101, 32'h0, 0);
    #1 check("hole accept", 64'(bus.in_accept_num), 64'd1);
    tick(); idle();
    check("hole count", 64'(bus.count), 64'd1);
    check("hole pc0", 64'(bus.out_PC[0]), 64'h0);
    drive(1'b0, '0, '0, 1); tick();

    // Near full: registered free slots limit the push despite a same-cycle pop.
    drive(1'b0, 3'b111, 32'h100, 0); tick();
    drive(1'b0, 3'b111, 32'h200, 0); tick();
    drive(1'b0, 3'b001, 32'h300, 0); tick();
    drive(1'b0, 3'b111, 32'h400, 2);
    #1 check("near-full accept", 64'(bus.in_accept_num), 64'd1);
    tick(); idle();
    check("near-full count", 64'(bus.count), 64'd6);
    drive(1'b0, 3'b111, 32'h500, 0); tick();
    drive(1'b0, 3'b111, 32'h600, 1);
    #1 check("full accept", 64'(bus.in_accept_num), 64'd0);
    tick(); idle();
    check("full pop count", 64'(bus.count), 64'd7);

    // Mid-stream asynchronous reset with live entries.
    #1 async_reset_check("async reset");

    // Pointer wrap: entries land at indices 6, 7, 0.
    drive(1'b0, 3'b111, 32'h10, 0); tick();
    drive(1'b0, 3'b111, 32'h1c, 0); tick();
    drive(1'b0, '0, '0, 3); tick();
    drive(1'b0, '0, '0, 3); tick();
    drive(1'b0, 3'b111, 32'h40, 0); tick(); idle();
    check("wrap count", 64'(bus.count), 64'd3);
    check("wrap pc0", 64'(bus.out_PC[0]), 64'h40);
    check("wrap pc1", 64'(bus.out_PC[1]), 64'h44);
    check("wrap pc2", 64'(bus.out_PC[2]), 64'h48);
    drive(1'b0, '0, '0, 3); tick();

    // Flush overrides same-cycle push and pop.
    drive(1'b0, 3'b111, 32'h80, 0); tick();
    drive(1'b0, 3'b011, 32'h90, 0); tick();
    drive(1'b1, 3'b111, 32'ha0, 2);
    #1 check("flush accept", 64'(bus.in_accept_num), 64'd0);
    tick(); idle();
    check("flush count", 64'(bus.count), 64'd0);
    check("flush out_valid", 64'(bus.out_valid), 64'd0);

    // Over-dispatch saturates the pop and latches the sticky error.
    drive(1'b0, 3'b001, 32'hb0, 0); tick();
    drive(1'b0, '0, '0, 3); tick(); idle();
    check("underflow count", 64'(bus.count), 64'd0);
    check("underflow flag", 64'(bus.underflow_err), 64'd1);
    repeat (3) tick();
    check("underflow sticky", 64'(bus.underflow_err), 64'd1);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 24) == 0), N_WAY'($urandom), $urandom, int'($urandom_range(0, N_WAY)));
      tick();
      if (c == 200) async_reset_check("random reset");
    end

    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
